// File: rtl/bullet_pkg.sv
// Shared widths, timing constants and FSM encoding
// for the bullet memory scheduler.
package bullet_pkg;

  localparam int DATA_W = 24;
  localparam int ADDR_W = 6;
  localparam int ROW_W  = 11;
  localparam int CNT_W  = 16;

  localparam logic [ROW_W-1:0] V_ACTIVE = 11'd1080;

  typedef enum logic [1:0] {
    ACTIVE = 2'd0,
    START  = 2'd1,
    UPDATE = 2'd2,
    DONE   = 2'd3
  } state_e;

  localparam logic OWN_REN = 1'b0;
  localparam logic OWN_UPD = 1'b1;

endpackage

// File: rtl/bullet_mem_scheduler.sv
// Shares bullet_memory between the scanline renderer and the
// per-frame update engine, which runs only during vertical blanking.
module bullet_mem_scheduler
  import bullet_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic [ROW_W-1:0]  display_row,
  input  logic [ADDR_W-1:0] ren_rdaddr,
  input  logic [ADDR_W-1:0] upd_rdaddr,
  input  logic [ADDR_W-1:0] upd_wraddr,
  input  logic [DATA_W-1:0] upd_wrdata,
  input  logic              upd_wren,
  input  logic              upd_done,
  input  logic [DATA_W-1:0] mem_q,
  output logic [ADDR_W-1:0] mem_rdaddr,
  output logic [ADDR_W-1:0] mem_wraddr,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_wren,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_owner,
  output logic              calc,
  output logic              upd_start,
  output logic              overrun,
  output logic [CNT_W-1:0]  frame_count
);

  state_e state, state_nx;
  logic   blank, blank_q;
  logic   win_start, win_end;
  logic   grant;
  logic   done_hit, abort_hit;

  assign blank     = (display_row >= V_ACTIVE);
  assign win_start = blank & ~blank_q;
  assign win_end   = ~blank & blank_q;

  assign done_hit  = (state == UPDATE) & upd_done;
  assign abort_hit = (state == UPDATE) & win_end & ~upd_done;

  // blank_q resets high so a reset released
  // inside blanking never opens a window
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) blank_q <= 1'b1;
    else        blank_q <= blank;
  end

  // state register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= ACTIVE;
    else        state <= state_nx;
  end

  // next state, grant and handshake outputs
  always_comb begin
    state_nx  = state;
    grant     = OWN_REN;
    calc      = 1'b0;
    upd_start = 1'b0;
    mem_wren  = 1'b0;
    unique case (state)
      ACTIVE: begin
        if (win_start) state_nx = START;
      end
      START: begin
        upd_start = 1'b1;
        calc      = 1'b1;
        grant     = OWN_UPD;
        state_nx  = UPDATE;
      end
      UPDATE: begin
        calc     = 1'b1;
        grant    = OWN_UPD;
        mem_wren = upd_wren;
        if (upd_done)     state_nx = win_end ? ACTIVE : DONE;
        else if (win_end) state_nx = ACTIVE;
      end
      DONE: begin
        if (win_end) state_nx = ACTIVE;
      end
      default: state_nx = ACTIVE;
    endcase
  end

  // port mux follows the current grant
  always_comb begin
    mem_rdaddr = (grant == OWN_UPD) ? upd_rdaddr : ren_rdaddr;
    mem_wraddr = (grant == OWN_UPD) ? upd_wraddr : '0;
    mem_data   = (grant == OWN_UPD) ? upd_wrdata : '0;
  end

  assign rd_data = mem_q;

  // memory read is registered, so the tag lags grant by one
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) rd_owner <= 1'b0;
    else        rd_owner <= grant;
  end

  // completed-update counter
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)        frame_count <= '0;
    else if (done_hit) frame_count <= frame_count + CNT_W'(1);
  end

  // overrun: cleared as a new window opens, set on abort
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                              overrun <= 1'b0;
    else if (state == ACTIVE && win_start)   overrun <= 1'b0;
    else if (abort_hit)                      overrun <= 1'b1;
  end

endmodule

// File: tb/tb_bullet_mem_scheduler.sv
// Self-checking bench for bullet_mem_scheduler:
// window detection, port muxing, overrun and async reset.
module tb_bullet_mem_scheduler;
  import bullet_pkg::*;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic [ROW_W-1:0]  display_row = 11'd1100;
  logic [ADDR_W-1:0] ren_rdaddr = '0;
  logic [ADDR_W-1:0] upd_rdaddr = '0;
  logic [ADDR_W-1:0] upd_wraddr = '0;
  logic [DATA_W-1:0] upd_wrdata = '0;
  logic              upd_wren = 1'b0;
  logic              upd_done = 1'b0;
  logic [DATA_W-1:0] mem_q = '0;
  logic [ADDR_W-1:0] mem_rdaddr;
  logic [ADDR_W-1:0] mem_wraddr;
  logic [DATA_W-1:0] mem_data;
  logic              mem_wren;
  logic [DATA_W-1:0] rd_data;
  logic              rd_owner;
  logic              calc;
  logic              upd_start;
  logic              overrun;
  logic [CNT_W-1:0]  frame_count;

  int errors = 0;
  int checks = 0;
  int pulses;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  wr_t  wr_q[$];
  logic own_q[$];
  int   exp_cnt = 0;

  bullet_mem_scheduler dut (
    .clock(clock), .reset(reset),
    .display_row(display_row),
    .ren_rdaddr(ren_rdaddr),
    .upd_rdaddr(upd_rdaddr),
    .upd_wraddr(upd_wraddr),
    .upd_wrdata(upd_wrdata),
    .upd_wren(upd_wren),
    .upd_done(upd_done),
    .mem_q(mem_q),
    .mem_rdaddr(mem_rdaddr),
    .mem_wraddr(mem_wraddr),
    .mem_data(mem_data),
    .mem_wren(mem_wren),
    .rd_data(rd_data),
    .rd_owner(rd_owner),
    .calc(calc),
    .upd_start(upd_start),
    .overrun(overrun),
    .frame_count(frame_count)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
    if (upd_start === 1'b1) pulses++;
  endtask

  // walk rows one per clock, from a to b inclusive
  task automatic walk(input int a, input int b);
    for (int r = a; r <= b; r++) begin
      display_row = ROW_W'(r);
      step();
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    display_row = 11'd1100;
    #3;
    checks++;
    if ({calc, upd_start, mem_wren, overrun, rd_owner} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags got=%b exp=00000",
               {calc, upd_start, mem_wren, overrun, rd_owner});
    end
    checks++;
    if (frame_count !== '0) begin
      errors++;
      $display("FAIL reset_count got=%0d exp=0", frame_count);
    end
    @(negedge clock);
    reset = 1'b1;
    pulses = 0;
    walk(1100, 1110);
    checks++;
    if (pulses !== 0) begin
      errors++;
      $display("FAIL no_start_in_blank got=%0d exp=0", pulses);
    end
  endtask

  task automatic test_window_start();
    walk(0, 3);
    walk(1079, 1079);
    checks++;
    if (pulses !== 0) begin
      errors++;
      $display("FAIL start_early got=%0d exp=0", pulses);
    end
    walk(1080, 1080);
    checks++;
    if (upd_start !== 1'b1 || calc !== 1'b1) begin
      errors++;
      $display("FAIL start_pulse got=%b%b exp=11", upd_start, calc);
    end
    walk(1081, 1085);
    checks++;
    if (pulses !== 1) begin
      errors++;
      $display("FAIL start_count got=%0d exp=1", pulses);
    end
  endtask

  task automatic test_update_write();
    wr_t w;
    checks++;
    if (calc !== 1'b1) begin
      errors++;
      $display("FAIL calc_update got=%b exp=1", calc);
    end
    upd_wren = 1'b1;
    upd_wraddr = 6'd5;
    upd_wrdata = 24'h00A001;
    upd_rdaddr = 6'd9;
    ren_rdaddr = 6'd3;
    wr_q.push_back('{6'd5, 24'h00A001});
    own_q.push_back(OWN_UPD);
    #1;
    checks++;
    if (mem_wren !== 1'b1) begin
      errors++;
      $display("FAIL upd_wren got=%b exp=1", mem_wren);
    end else begin
      w = wr_q.pop_front();
      checks++;
      if (mem_wraddr !== w.addr || mem_data !== w.data) begin
        errors++;
        $display("FAIL upd_write got=%0d/%h exp=%0d/%h",
                 mem_wraddr, mem_data, w.addr, w.data);
      end
    end
    checks++;
    if (mem_rdaddr !== 6'd9) begin
      errors++;
      $display("FAIL upd_rdaddr got=%0d exp=9", mem_rdaddr);
    end
    mem_q = 24'h123456;
    step();
    checks++;
    if (rd_owner !== own_q.pop_front() || rd_data !== 24'h123456) begin
      errors++;
      $display("FAIL rd_owner_upd got=%b/%h exp=1/123456",
               rd_owner, rd_data);
    end
    upd_done = 1'b1;
    exp_cnt++;
    step();
    upd_done = 1'b0;
    #1;
    checks++;
    if (calc !== 1'b0 || frame_count !== CNT_W'(exp_cnt)) begin
      errors++;
      $display("FAIL done got=%b/%0d exp=0/%0d",
               calc, frame_count, exp_cnt);
    end
    checks++;
    if (mem_wren !== 1'b0) begin
      errors++;
      $display("FAIL done_wren got=%b exp=0", mem_wren);
    end
  endtask

  task automatic test_renderer();
    walk(1090, 1124);
    walk(0, 10);
    ren_rdaddr = 6'd42;
    own_q.push_back(OWN_REN);
    #1;
    checks++;
    if (mem_wren !== 1'b0) begin
      errors++;
      $display("FAIL ren_wren got=%b exp=0", mem_wren);
    end
    checks++;
    if (mem_rdaddr !== 6'd42) begin
      errors++;
      $display("FAIL ren_rdaddr got=%0d exp=42", mem_rdaddr);
    end
    step();
    checks++;
    if (rd_owner !== own_q.pop_front()) begin
      errors++;
      $display("FAIL rd_owner_ren got=%b exp=0", rd_owner);
    end
    upd_wren = 1'b0;
  endtask

  task automatic test_overrun();
    walk(1079, 1124);
    walk(0, 0);
    checks++;
    if (overrun !== 1'b1 || calc !== 1'b0) begin
      errors++;
      $display("FAIL overrun_set got=%b/%b exp=1/0", overrun, calc);
    end
    checks++;
    if (frame_count !== CNT_W'(exp_cnt)) begin
      errors++;
      $display("FAIL overrun_cnt got=%0d exp=%0d", frame_count, exp_cnt);
    end
    walk(1, 4);
    walk(1079, 1082);
    checks++;
    if (overrun !== 1'b0 || calc !== 1'b1) begin
      errors++;
      $display("FAIL overrun_clr got=%b/%b exp=0/1", overrun, calc);
    end
  endtask

  task automatic test_done_at_end();
    walk(1083, 1124);
    display_row = 11'd0;
    upd_done = 1'b1;
    exp_cnt++;
    step();
    upd_done = 1'b0;
    #1;
    checks++;
    if (overrun !== 1'b0 || calc !== 1'b0) begin
      errors++;
      $display("FAIL done_end got=%b/%b exp=0/0", overrun, calc);
    end
    checks++;
    if (frame_count !== CNT_W'(exp_cnt)) begin
      errors++;
      $display("FAIL done_end_cnt got=%0d exp=%0d", frame_count, exp_cnt);
    end
    walk(1, 4);
    upd_done = 1'b1;
    step();
    upd_done = 1'b0;
    checks++;
    if (frame_count !== CNT_W'(exp_cnt)) begin
      errors++;
      $display("FAIL done_ignored got=%0d exp=%0d", frame_count, exp_cnt);
    end
  endtask

  task automatic test_async_reset();
    walk(1079, 1082);
    upd_wren = 1'b1;
    #1;
    checks++;
    if (mem_wren !== 1'b1 || calc !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset got=%b/%b exp=1/1", mem_wren, calc);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (calc !== 1'b0 || mem_wren !== 1'b0 || frame_count !== '0) begin
      errors++;
      $display("FAIL async_reset got=%b/%b/%0d exp=0/0/0",
               calc, mem_wren, frame_count);
    end
    upd_wren = 1'b0;
    display_row = 11'd1100;
    @(negedge clock);
    reset = 1'b1;
    pulses = 0;
    walk(1100, 1124);
    walk(0, 2);
    walk(1079, 1079);
    checks++;
    if (pulses !== 0) begin
      errors++;
      $display("FAIL post_reset_early got=%0d exp=0", pulses);
    end
    walk(1080, 1086);
    checks++;
    if (pulses !== 1) begin
      errors++;
      $display("FAIL post_reset_start got=%0d exp=1", pulses);
    end
  endtask

  initial begin
    test_reset();
    test_window_start();
    test_update_write();
    test_renderer();
    test_overrun();
    test_done_at_end();
    test_async_reset();
    checks++;
    if (wr_q.size() != 0 || own_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_left got=%0d/%0d exp=0/0",
               wr_q.size(), own_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
